// File: rtl/debug_pkg.sv
// Shared definitions for the debug run controller: command bytes, FSM states, END marker.
// Pure declarations; no timing or flow-control behaviour of its own.
package debug_pkg;

    localparam logic [7:0]  CMD_RUN   = 8'h63;
    localparam logic [7:0]  CMD_STEP  = 8'h73;
    localparam logic [7:0]  CMD_HALT  = 8'h68;
    localparam logic [7:0]  CMD_DUMP  = 8'h72;

    localparam logic [31:0] END_INSTR = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        DUMP_ADDR,
        DUMP_WAIT,
        DUMP_CAP,
        DUMP_SEND
    } state_t;

endpackage

// File: rtl/word_serializer.sv
// Loads one DATA_W word and emits it MSB byte first; first byte valid the cycle after load.
// Holds the current byte while !i_tx_ready; o_done pulses combinationally with the last transfer.
module word_serializer #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_word,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_done
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    logic [DATA_W-1:0] word_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              vld_q;
    logic              xfer;

    assign xfer       = vld_q && i_tx_ready;
    assign o_done     = xfer && (cnt_q == CNT_W'(1));
    assign o_tx_valid = vld_q;
    // Output byte is the top of the shift register, so it drains to zero after the last byte.
    assign o_tx_data  = word_q[DATA_W-1 -: 8];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            word_q <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
        end else if (i_load) begin
            word_q <= i_word;
            cnt_q  <= CNT_W'(NBYTES);
            vld_q  <= 1'b1;
        end else if (xfer) begin
            word_q <= word_q << 8;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/debug_run_controller.sv
// Debug sequencer owning pipeline halt and the debug register read port; dumps all registers as bytes.
// Register data sampled READ_LAT clocks after address change; TX holds each byte until i_tx_ready.
module debug_run_controller
    import debug_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cmd_valid,
    input  logic [7:0]        i_cmd,
    output logic              o_cmd_ready,
    input  logic              i_program_end,
    output logic              o_halt,
    output logic [ADDR_W-1:0] o_reg_read,
    input  logic [DATA_W-1:0] i_reg_content,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_ended,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [1:0]        LAT      = 2'(READ_LAT);

    state_t            state_q;
    logic              halt_q;
    logic              ended_q;
    logic              busy_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] rd_q;
    logic [1:0]        wait_q;

    logic              cmd_acc;
    logic              ser_load;
    logic              ser_done;

    assign o_cmd_ready = (state_q == IDLE) || (state_q == RUN);
    assign cmd_acc     = i_cmd_valid && o_cmd_ready;
    assign ser_load    = (state_q == DUMP_CAP);

    assign o_halt      = halt_q;
    assign o_ended     = ended_q;
    assign o_busy      = busy_q;
    assign o_reg_read  = rd_q;

    word_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (ser_load),
        .i_word     (i_reg_content),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_done     (ser_done)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            halt_q  <= 1'b1;
            ended_q <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            rd_q    <= '0;
            wait_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_acc) begin
                        if (i_cmd == CMD_RUN && !ended_q) begin
                            state_q <= RUN;
                            halt_q  <= 1'b0;
                            busy_q  <= 1'b1;
                        end else if (i_cmd == CMD_STEP && !ended_q) begin
                            state_q <= STEP;
                            halt_q  <= 1'b0;
                            busy_q  <= 1'b1;
                        end else if (i_cmd == CMD_DUMP) begin
                            state_q <= DUMP_ADDR;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // END in ID wins over a halt command arriving in the same cycle.
                    if (i_program_end) begin
                        halt_q  <= 1'b1;
                        ended_q <= 1'b1;
                        idx_q   <= '0;
                        state_q <= DUMP_ADDR;
                    end else if (cmd_acc && i_cmd == CMD_HALT) begin
                        halt_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                STEP: begin
                    halt_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (i_program_end) begin
                        ended_q <= 1'b1;
                    end
                end
                DUMP_ADDR: begin
                    rd_q    <= idx_q;
                    wait_q  <= LAT;
                    state_q <= (LAT == 2'd0) ? DUMP_CAP : DUMP_WAIT;
                end
                DUMP_WAIT: begin
                    if (wait_q <= 2'd1) begin
                        wait_q  <= 2'd0;
                        state_q <= DUMP_CAP;
                    end else begin
                        wait_q  <= wait_q - 2'd1;
                    end
                end
                DUMP_CAP: begin
                    state_q <= DUMP_SEND;
                end
                DUMP_SEND: begin
                    if (ser_done) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            rd_q    <= '0;
                            idx_q   <= '0;
                        end else begin
                            idx_q   <= idx_q + ADDR_W'(1);
                            state_q <= DUMP_ADDR;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_run_controller.sv
// Self-checking bench for debug_run_controller: directed command sequence with random register
// contents and random sink stalls, dump stream compared against a byte list built from the bank.
module tb_debug_run_controller;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int READ_LAT = 2;
    localparam int NBYTES   = NUM_REGS * DATA_W / 8;

    logic              i_clk = 1'b0;
    logic              i_reset_n = 1'b0;
    logic              i_cmd_valid = 1'b0;
    logic [7:0]        i_cmd = 8'h00;
    logic              o_cmd_ready;
    logic              i_program_end;
    logic              o_halt;
    logic [ADDR_W-1:0] o_reg_read;
    logic [DATA_W-1:0] i_reg_content;
    logic [7:0]        o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready = 1'b1;
    logic              o_ended;
    logic              o_busy;

    logic [31:0]       id_instr = 32'h0000_0013;
    logic [DATA_W-1:0] bank [NUM_REGS];
    logic [DATA_W-1:0] pipe1, pipe2;

    logic [7:0] rx_q [$];
    int         rd_log [$];
    int         n_assert = 0;
    int         n_fail = 0;
    int         stall_viol = 0;
    int         halt_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 i_clk = ~i_clk;

    assign i_program_end = (id_instr == debug_pkg::END_INSTR);

    // Register bank with READ_LAT clocks of read latency.
    always @(posedge i_clk) begin
        pipe1 <= bank[o_reg_read];
        pipe2 <= pipe1;
    end
    assign i_reg_content = pipe2;

    debug_run_controller #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_cmd_valid   (i_cmd_valid),
        .i_cmd         (i_cmd),
        .o_cmd_ready   (o_cmd_ready),
        .i_program_end (i_program_end),
        .o_halt        (o_halt),
        .o_reg_read    (o_reg_read),
        .i_reg_content (i_reg_content),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .i_tx_ready    (i_tx_ready),
        .o_ended       (o_ended),
        .o_busy        (o_busy)
    );

    always @(posedge i_clk) begin
        if (i_reset_n) begin
            if (o_tx_valid && i_tx_ready) begin
                if (rx_q.size() % 4 == 0) rd_log.push_back(int'(o_reg_read));
                rx_q.push_back(o_tx_data);
            end
            if (prev_stall && (!o_tx_valid || o_tx_data !== prev_data)) stall_viol++;
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_data  = o_tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c);
        int n;
        n = 0;
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        while (!o_cmd_ready && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        check("cmd_accept", 32'(n < 500), 32'd1);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic clear_logs();
        rx_q.delete();
        rd_log.delete();
        stall_viol = 0;
        halt_viol  = 0;
    endtask

    task automatic fill_bank(input bit random);
        for (int i = 0; i < NUM_REGS; i++) begin
            bank[i] = random ? $urandom() : (32'h0102_0300 + 32'(i));
        end
    endtask

    task automatic run_dump(input int mode, input string tag);
        int cyc;
        cyc = 0;
        while (!(rx_q.size() >= NBYTES && !o_busy) && cyc < 5000) begin
            @(negedge i_clk);
            cyc++;
            case (mode)
                0:       i_tx_ready = 1'b1;
                1:       i_tx_ready = (cyc % 3 == 0);
                default: i_tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (o_halt !== 1'b1) halt_viol++;
        end
        i_tx_ready = 1'b1;
        check({tag, "_done"}, 32'(cyc < 5000), 32'd1);
    endtask

    function automatic logic [31:0] rx_word(input int k);
        if (4 * k + 3 < rx_q.size())
            return {rx_q[4*k], rx_q[4*k+1], rx_q[4*k+2], rx_q[4*k+3]};
        return 'x;
    endfunction

    task automatic compare_dump(input string tag);
        int bad;
        int rbad;
        bad  = 0;
        rbad = 0;
        check({tag, "_len"}, 32'(rx_q.size()), 32'(NBYTES));
        for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (i * 4 + b >= rx_q.size() || rx_q[i*4+b] !== bank[i][DATA_W-1-8*b -: 8]) bad++;
            end
        end
        check({tag, "_bytes_bad"}, 32'(bad), 32'd0);
        check({tag, "_addr_cnt"}, 32'(rd_log.size()), 32'(NUM_REGS));
        for (int i = 0; i < rd_log.size(); i++) begin
            if (rd_log[i] != i) rbad++;
        end
        check({tag, "_addr_bad"}, 32'(rbad), 32'd0);
        check({tag, "_stall_hold"}, 32'(stall_viol), 32'd0);
        check({tag, "_halt_hi"}, 32'(halt_viol), 32'd0);
    endtask

    initial begin
        int k;
        logic [7:0] c;

        fill_bank(1'b0);

        // Reset values, no clock edge required.
        #12;
        check("rst_out", {28'd0, o_halt, o_tx_valid, o_busy, o_ended}, 32'b1000);
        check("rst_data", {24'd0, o_tx_data}, 32'h00);
        check("rst_addr", 32'(o_reg_read), 32'd0);
        check("rst_ready", 32'(o_cmd_ready), 32'd1);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            check("idle_state", {28'd0, o_halt, o_tx_valid, o_cmd_ready, o_busy}, 32'b1010);
        end

        // Single step: halt low for exactly one cycle.
        send_cmd(8'h73);
        check("step_halt_lo", {30'd0, o_halt, o_busy}, 32'b01);
        @(negedge i_clk);
        check("step_halt_hi", {29'd0, o_halt, o_busy, o_cmd_ready}, 32'b101);
        @(negedge i_clk);
        check("step_stay_hi", 32'(o_halt), 32'd1);

        // Run for a while, halt, then dump the known pattern.
        send_cmd(8'h63);
        for (int i = 0; i < 5; i++) begin
            check("run_halt_lo", {30'd0, o_halt, o_ended}, 32'b00);
            @(negedge i_clk);
        end
        send_cmd(8'h68);
        check("halt_cmd", {30'd0, o_halt, o_busy}, 32'b10);
        clear_logs();
        send_cmd(8'h72);
        check("dump_busy", {30'd0, o_busy, o_cmd_ready}, 32'b10);
        run_dump(0, "dump0");
        compare_dump("dump0");
        check("dump0_first", rx_word(0), 32'h0102_0300);
        check("dump0_last", rx_word(NUM_REGS - 1), 32'h0102_031F);
        check("dump0_addr_end", 32'(o_reg_read), 32'd0);

        // Sink ready only one cycle in three, then random ready.
        fill_bank(1'b1);
        clear_logs();
        send_cmd(8'h72);
        run_dump(1, "bp");
        compare_dump("bp");
        fill_bank(1'b1);
        clear_logs();
        send_cmd(8'h72);
        run_dump(2, "rnd");
        compare_dump("rnd");

        // Halt and unknown bytes in IDLE are consumed with no effect.
        for (int i = 0; i < 12; i++) begin
            c = 8'($urandom_range(0, 255));
            if (c == 8'h63 || c == 8'h73 || c == 8'h72) c = 8'h68;
            send_cmd(c);
            check("idle_junk", {29'd0, o_halt, o_busy, o_tx_valid}, 32'b100);
        end

        // Random run lengths; a dump request while running is dropped.
        for (int r = 0; r < 3; r++) begin
            send_cmd(8'h63);
            k = int'($urandom_range(1, 8));
            for (int i = 0; i < k; i++) begin
                check("rnd_run_lo", 32'(o_halt), 32'd0);
                @(negedge i_clk);
            end
            send_cmd(8'h72);
            @(negedge i_clk);
            check("run_drop_r", {29'd0, o_halt, o_busy, o_tx_valid}, 32'b010);
            send_cmd(8'h68);
            check("rnd_halt", {30'd0, o_halt, o_busy}, 32'b10);
        end

        // END and 'h' together while running: END wins, auto dump follows.
        fill_bank(1'b1);
        send_cmd(8'h63);
        repeat (3) @(negedge i_clk);
        clear_logs();
        id_instr    = debug_pkg::END_INSTR;
        i_cmd_valid = 1'b1;
        i_cmd       = 8'h68;
        @(negedge i_clk);
        id_instr    = 32'h0000_0013;
        i_cmd_valid = 1'b0;
        check("end_flags", {29'd0, o_ended, o_halt, o_busy}, 32'b111);
        run_dump(0, "auto");
        compare_dump("auto");
        send_cmd(8'h63);
        for (int i = 0; i < 3; i++) begin
            check("ended_run_ign", {29'd0, o_halt, o_busy, o_ended}, 32'b101);
            @(negedge i_clk);
        end
        send_cmd(8'h73);
        check("ended_step_ign", {29'd0, o_halt, o_busy, o_ended}, 32'b101);

        // Async reset after byte 10 of a dump, then a fresh dump.
        fill_bank(1'b1);
        clear_logs();
        send_cmd(8'h72);
        k = 0;
        while (rx_q.size() < 10 && k < 2000) begin
            @(negedge i_clk);
            k++;
        end
        check("pre_rst_bytes", 32'(k < 2000), 32'd1);
        #2 i_reset_n = 1'b0;
        #1;
        check("arst_out", {28'd0, o_halt, o_tx_valid, o_busy, o_ended}, 32'b1000);
        check("arst_data", {24'd0, o_tx_data}, 32'h00);
        check("arst_addr", 32'(o_reg_read), 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        clear_logs();
        send_cmd(8'h72);
        run_dump(2, "post_rst");
        compare_dump("post_rst");

        // END during a step: flag set, no dump.
        send_cmd(8'h73);
        id_instr = debug_pkg::END_INSTR;
        @(negedge i_clk);
        id_instr = 32'h0000_0013;
        check("step_end", {29'd0, o_ended, o_halt, o_busy}, 32'b110);
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            check("step_end_nodump", {30'd0, o_tx_valid, o_busy}, 32'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
